// File: rtl/board_writer.sv
// board_writer: buffers cell-write / board-fill commands from the game logic
// in a small FIFO and drains them into the board RAM write port. With
// SYNC_WRITES=1, RAM writes are only issued while the display is in vertical
// blanking, so a displayed frame never shows a half-updated board.
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is combinationally !full. While cmd_ready is low, the source must
// hold cmd_valid and the command fields stable.
module board_writer #(
  parameter int COLS        = 32,
  parameter int ROWS        = 20,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int XY_W        = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_WRITES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [XY_W-1:0]   cmd_x,
  input  logic [XY_W-1:0]   cmd_y,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              vblank,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              err,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = 2 + 2 * XY_W + DATA_W;

  localparam logic [1:0]        OP_WRITE  = 2'b00;
  localparam logic [1:0]        OP_FILL   = 2'b01;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);
  localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  // Storage array carries no reset: entries are only read when count_q says so.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {cmd_op, cmd_x, cmd_y, cmd_data};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head-of-FIFO fields
  logic [ENT_W-1:0]  head;
  logic [1:0]        head_op;
  logic [XY_W-1:0]   head_x;
  logic [XY_W-1:0]   head_y;
  logic [DATA_W-1:0] head_data;

  assign head = fifo_q[rd_ptr_q];
  assign {head_op, head_x, head_y, head_data} = head;

  // ---------------------------------------------------------------------------
  // Write gate, address mapping, range check
  // ---------------------------------------------------------------------------
  logic              gate;
  logic              in_range;
  logic [ADDR_W-1:0] cell_addr;

  assign gate      = vblank || (SYNC_WRITES == 0);
  assign in_range  = (32'(head_x) < COLS) && (32'(head_y) < ROWS);
  assign cell_addr = ADDR_W'(32'(head_y) * 32'(COLS) + 32'(head_x));

  // ---------------------------------------------------------------------------
  // Control FSM and registered write port
  // ---------------------------------------------------------------------------
  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic              we_q,       we_d;
  logic [ADDR_W-1:0] waddr_q,    waddr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic              err_q,      err_d;

  // State, fill progress and write-port registers; reset abandons any fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
      fill_val_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      fill_val_q <= fill_val_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: IDLE pops one command per open-gate cycle; FILL sweeps
  // every cell address once, pausing whenever the gate is closed.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    fill_val_d = fill_val_q;
    we_d       = 1'b0;
    err_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty && gate) begin
          pop = 1'b1;
          case (head_op)
            OP_WRITE: begin
              if (in_range) begin
                we_d    = 1'b1;
                waddr_d = cell_addr;
                wdata_d = head_data;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_FILL: begin
              fill_val_d = head_data;
              fill_cnt_d = '0;
              state_d    = ST_FILL;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      ST_FILL: begin
        if (gate) begin
          we_d    = 1'b1;
          waddr_d = fill_cnt_q;
          wdata_d = fill_val_q;
          if (fill_cnt_q == LAST_ADDR) begin
            fill_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            fill_cnt_d = fill_cnt_q + ADDR_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign err   = err_q;
  assign busy  = !empty || (state_q == ST_FILL) || we_q;

endmodule

// File: tb/tb_board_writer.sv
// Testbench for board_writer: directed vectors against a frame-synchronised
// instance (default geometry) and a free-running instance with COLS=24.
module tb_board_writer;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int XW = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: SYNC_WRITES=1, 32x20
  logic          c_valid = 1'b0;
  logic          c_ready;
  logic [1:0]    c_op = 2'b00;
  logic [XW-1:0] c_x = '0;
  logic [XW-1:0] c_y = '0;
  logic [DW-1:0] c_data = '0;
  logic          vblank = 1'b0;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          err;
  logic          busy;

  // Instance 1: SYNC_WRITES=0, 24x20
  logic          d_valid = 1'b0;
  logic          d_ready;
  logic [1:0]    d_op = 2'b00;
  logic [XW-1:0] d_x = '0;
  logic [XW-1:0] d_y = '0;
  logic [DW-1:0] d_data = '0;
  logic          d_vblank = 1'b0;
  logic          d_we;
  logic [AW-1:0] d_waddr;
  logic [DW-1:0] d_wdata;
  logic          d_err;
  logic          d_busy;

  board_writer dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(c_valid), .cmd_ready(c_ready), .cmd_op(c_op),
    .cmd_x(c_x), .cmd_y(c_y), .cmd_data(c_data),
    .vblank(vblank),
    .we(we), .waddr(waddr), .wdata(wdata), .err(err), .busy(busy)
  );

  board_writer #(.COLS(24), .SYNC_WRITES(0)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(d_valid), .cmd_ready(d_ready), .cmd_op(d_op),
    .cmd_x(d_x), .cmd_y(d_y), .cmd_data(d_data),
    .vblank(d_vblank),
    .we(d_we), .waddr(d_waddr), .wdata(d_wdata), .err(d_err), .busy(d_busy)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard for instance 0 writes: {addr, data} in issue order
  // ---------------------------------------------------------------------------
  logic [AW+DW-1:0] exp_q[$];
  int   wr_cnt = 0;
  int   err_cnt = 0;
  logic gate_prev = 1'b0;

  always @(posedge clk) gate_prev <= vblank;

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (!reset) begin
      if (!gate_prev) check("we_while_gate_closed", 32'(we), 0);
      if (err) err_cnt++;
      if (we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_we", 32'(we), 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_waddr", 32'(waddr), 32'(e[AW+DW-1:DW]));
          check("sb_wdata", 32'(wdata), 32'(e[DW-1:0]));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int addr, input int d);
    exp_q.push_back({AW'(addr), DW'(d)});
  endtask

  task automatic push(input logic [1:0] op, input int x, input int y, input int d);
    int n;
    n = 0;
    c_valid = 1'b1;
    c_op    = op;
    c_x     = XW'(x);
    c_y     = XW'(y);
    c_data  = DW'(d);
    while (!c_ready && n < 100) begin
      tick();
      n++;
    end
    if (!c_ready) check("push_timeout", 32'(c_ready), 1);
    tick();
    c_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_we", 32'(we), 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready_held", 32'(c_ready), 1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_ready_after", 32'(c_ready), 1);
    check("rst_busy_after", 32'(busy), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int wr_before;
    int err_before;
    int cyc;

    // Test 1: single in-range WRITE during vblank
    vblank = 1'b1;
    do_reset();
    expect_wr(67, 8'h05);
    push(2'b00, 3, 2, 8'h05);
    check("t1_busy_queued", 32'(busy), 1);
    check("t1_we_before_pop", 32'(we), 0);
    tick();
    check("t1_we", 32'(we), 1);
    check("t1_waddr", 32'(waddr), 67);
    check("t1_wdata", 32'(wdata), 8'h05);
    check("t1_err", 32'(err), 0);
    check("t1_busy_during_we", 32'(busy), 1);
    tick();
    check("t1_we_clear", 32'(we), 0);
    check("t1_busy_fall", 32'(busy), 0);
    check("t1_waddr_hold", 32'(waddr), 67);

    // Test 2: FIFO fills while gate closed, drains in order when vblank rises
    vblank = 1'b0;
    expect_wr(1,   8'h11);
    expect_wr(31,  8'h22);
    expect_wr(32,  8'h33);
    expect_wr(639, 8'h44);
    expect_wr(325, 8'h55);
    push(2'b00, 1, 0, 8'h11);
    push(2'b00, 31, 0, 8'h22);
    push(2'b00, 0, 1, 8'h33);
    push(2'b00, 31, 19, 8'h44);
    check("t2_full_ready", 32'(c_ready), 0);
    c_valid = 1'b1; c_op = 2'b00; c_x = 5'd5; c_y = 5'd10; c_data = 8'h55;
    tick();
    tick();
    check("t2_still_full", 32'(c_ready), 0);
    check("t2_no_we", 32'(we), 0);
    check("t2_busy", 32'(busy), 1);
    vblank = 1'b1;
    tick();
    check("t2_we0", 32'(we), 1);
    check("t2_ready_after_pop", 32'(c_ready), 1);
    tick();
    c_valid = 1'b0;
    check("t2_we1", 32'(we), 1);
    for (int k = 2; k < 5; k++) begin
      tick();
      check($sformatf("t2_we%0d", k), 32'(we), 1);
    end
    tick();
    check("t2_we_end", 32'(we), 0);
    check("t2_busy_end", 32'(busy), 0);

    // Test 3: out-of-range rows and reserved ops produce err pulses only
    err_before = err_cnt;
    wr_before  = wr_cnt;
    push(2'b00, 0, 20, 8'hA1);
    push(2'b00, 31, 31, 8'hA2);
    push(2'b10, 1, 1, 8'hA3);
    push(2'b11, 2, 2, 8'hA4);
    tick();
    check("t3_err_last", 32'(err), 1);
    tick();
    tick();
    check("t3_err_count", 32'(err_cnt - err_before), 4);
    check("t3_no_writes", 32'(wr_cnt - wr_before), 0);
    check("t3_err_clear", 32'(err), 0);
    check("t3_drained", 32'(busy), 0);

    // Test 4: FILL with vblank duty cycle, queued WRITE after last address
    wr_before = wr_cnt;
    for (int a = 0; a < 640; a++) expect_wr(a, 8'h01);
    expect_wr(34, 8'h77);
    push(2'b01, 0, 0, 8'h01);
    push(2'b00, 2, 1, 8'h77);
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 4000) begin
      vblank = ((cyc % 150) < 100);
      tick();
      cyc++;
    end
    check("t4_queue_empty", 32'(exp_q.size()), 0);
    check("t4_write_count", 32'(wr_cnt - wr_before), 641);
    check("t4_idle", 32'(busy), 0);

    // Test 5: asynchronous reset mid-FILL at address 300
    vblank = 1'b1;
    for (int a = 0; a <= 300; a++) expect_wr(a, 8'h3C);
    push(2'b01, 0, 0, 8'h3C);
    n = 0;
    while (!(we && waddr == AW'(300)) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_300", 32'(waddr), 300);
    #2;
    reset = 1'b1;
    #1;
    check("t5_we_async", 32'(we), 0);
    check("t5_waddr_async", 32'(waddr), 0);
    check("t5_wdata_async", 32'(wdata), 0);
    check("t5_busy_async", 32'(busy), 0);
    check("t5_ready_async", 32'(c_ready), 1);
    tick();
    tick();
    reset = 1'b0;
    check("t5_sb_consumed", 32'(exp_q.size()), 0);
    wr_before = wr_cnt;
    for (int k = 0; k < 20; k++) tick();
    check("t5_no_more_writes", 32'(wr_cnt - wr_before), 0);
    check("t5_ready", 32'(c_ready), 1);
    check("t5_fifo_empty", 32'(busy), 0);

    // Test 6: free-running instance (COLS=24), back-to-back pushes
    for (int i = 0; i < 8; i++) begin
      d_valid = 1'b1;
      d_op    = 2'b00;
      d_x     = XW'(i * 3);
      d_y     = XW'(i % 4);
      d_data  = DW'(8'h80 + i);
      tick();
      check($sformatf("t6_ready%0d", i), 32'(d_ready), 1);
      if (i > 0) begin
        check($sformatf("t6_we%0d", i - 1), 32'(d_we), 1);
        check($sformatf("t6_waddr%0d", i - 1), 32'(d_waddr), ((i - 1) % 4) * 24 + (i - 1) * 3);
        check($sformatf("t6_wdata%0d", i - 1), 32'(d_wdata), 8'h80 + i - 1);
      end
    end
    d_valid = 1'b0;
    tick();
    check("t6_we7", 32'(d_we), 1);
    check("t6_waddr7", 32'(d_waddr), 3 * 24 + 21);
    tick();
    check("t6_we_clear", 32'(d_we), 0);
    check("t6_busy_clear", 32'(d_busy), 0);
    // column 24 is out of range on this geometry
    d_valid = 1'b1; d_op = 2'b00; d_x = 5'd24; d_y = 5'd0; d_data = 8'hEE;
    tick();
    d_valid = 1'b0;
    tick();
    check("t6_err_col", 32'(d_err), 1);
    check("t6_no_we_col", 32'(d_we), 0);
    // last legal cell
    d_valid = 1'b1; d_op = 2'b00; d_x = 5'd23; d_y = 5'd19; d_data = 8'h5A;
    tick();
    d_valid = 1'b0;
    check("t6_err_clear", 32'(d_err), 0);
    tick();
    check("t6_we_last", 32'(d_we), 1);
    check("t6_waddr_last", 32'(d_waddr), 479);
    check("t6_wdata_last", 32'(d_wdata), 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
